accum_vector_arbiter: RTL and testbench

Round-robin arbiter that shares one AccumWarpLooper vector stage between `N_REQ` warp-looper requesters. Requesters are typically index-generation front ends for different configs. Each requester streams beats of (id, linear1, linear2, bofs, retire, islast). The arbiter grants one requester for a whole block (until its `islast` beat), forwards the beats through one output register to the vector stage, and routes each `fin` pulse from the vector stage back to the requester that owned the finished block.

---
 rtl/accum_vector_arbiter_pkg.sv | 38 +++
 rtl/accum_vector_arbiter_fifo.sv | 52 +++++
 rtl/accum_vector_arbiter.sv | 150 +++++++++++++++
 tb/tb_accum_vector_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_vector_arbiter_pkg.sv
// Shared types and helpers for the accumulator vector-stage arbiter.
package AccumArbPkg;

    // Fallback widths used when the instantiating config does not override them.
    localparam int DEF_N_CFG = 4;
    localparam int DEF_ABW   = 16;
    localparam int DEF_WBW   = 8;
    localparam int DEF_DIM   = 2;

    // Largest requester count the round-robin helper can scan.
    localparam int MAX_REQ   = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Owner index width; kept at least 1 so a 1-wide index always exists.
    function automatic int own_bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First ready requester at or after ptr, wrapping modulo n; -1 if none.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] rdy, input int n, input int ptr);
        logic [MAX_REQ-1:0] sh;
        int j;
        rr_pick = -1;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                sh = rdy >> j;
                if (sh[0]) rr_pick = j;
            end
        end
    endfunction

endpackage

// File: rtl/accum_vector_arbiter_fifo.sv
// Owner FIFO: remembers which requester owns each block still in flight.
module AccumFinOwnerFifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PBW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [PBW-1:0]          r_wp;
    logic [PBW-1:0]          r_rp;
    logic [PBW:0]            r_cnt;
    logic                    w_push;
    logic                    w_pop;

    assign o_full  = (r_cnt == (PBW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/accum_vector_arbiter.sv
// Round-robin, block-locked arbiter sharing one vector stage among N_REQ requesters.
module accum_vector_arbiter
    import AccumArbPkg::*;
#(
    parameter  int N_REQ     = 2,
    parameter  int N_CFG     = DEF_N_CFG,
    parameter  int ABW       = DEF_ABW,
    parameter  int FIN_DEPTH = 4,
    parameter  int WBW       = DEF_WBW,
    parameter  int DIM       = DEF_DIM,
    localparam int NCFG_BW   = $clog2(N_CFG + 1),
    localparam int OWN_BW    = own_bw(N_REQ)
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [N_REQ-1:0]                    req_rdy,
    output logic [N_REQ-1:0]                    req_ack,
    input  logic [N_REQ-1:0][NCFG_BW-1:0]       i_id,
    input  logic [N_REQ-1:0][ABW-1:0]           i_linear1,
    input  logic [N_REQ-1:0][ABW-1:0]           i_linear2,
    input  logic [N_REQ-1:0][DIM-1:0][WBW-1:0]  i_bofs,
    input  logic [N_REQ-1:0]                    i_retire,
    input  logic [N_REQ-1:0]                    i_islast,
    output logic                                dst_rdy,
    input  logic                                dst_ack,
    output logic [NCFG_BW-1:0]                  o_id,
    output logic [ABW-1:0]                      o_linear1,
    output logic [ABW-1:0]                      o_linear2,
    output logic [DIM-1:0][WBW-1:0]             o_bofs,
    output logic                                o_retire,
    output logic                                o_islast,
    input  logic                                fin_dval,
    output logic [N_REQ-1:0]                    o_fin_dval,
    output logic                                o_err
);
    arb_state_e              r_state;
    logic [OWN_BW-1:0]       r_own;
    logic [OWN_BW-1:0]       r_rr_ptr;
    logic                    r_dst_rdy;
    logic [NCFG_BW-1:0]      r_id;
    logic [ABW-1:0]          r_linear1;
    logic [ABW-1:0]          r_linear2;
    logic [DIM-1:0][WBW-1:0] r_bofs;
    logic                    r_retire;
    logic                    r_islast;
    logic                    r_err;

    int                      w_pick;
    logic                    w_has;
    logic [OWN_BW-1:0]       w_idx;
    logic [OWN_BW-1:0]       w_rr_next;
    logic                    w_slot_free;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_full;
    logic                    w_empty;
    logic [OWN_BW-1:0]       w_head;
    logic                    w_pop;

    AccumFinOwnerFifo #(.DEPTH(FIN_DEPTH), .W(OWN_BW)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_accept && w_last),
        .i_din   (w_idx),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Winner selection and ack; data fields only enter through islast gating.
    always_comb begin
        w_slot_free = !r_dst_rdy || dst_ack;
        w_pick      = -1;
        if (r_state == IDLE)
            w_pick = rr_pick(MAX_REQ'(req_rdy), N_REQ, int'(r_rr_ptr));
        else if (req_rdy[r_own])
            w_pick = int'(r_own);
        w_has     = (w_pick >= 0);
        w_idx     = w_pick[OWN_BW-1:0];
        w_last    = i_islast[w_idx];
        w_accept  = w_has && w_slot_free && !(w_last && w_full);
        w_rr_next = (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
        req_ack   = '0;
        if (w_accept) req_ack[w_idx] = 1'b1;
    end

    // Fin is routed to the oldest outstanding owner with no added latency.
    always_comb begin
        w_pop      = fin_dval && !w_empty;
        o_fin_dval = '0;
        if (w_pop) o_fin_dval[w_head] = 1'b1;
    end

    // Block lock FSM plus round-robin pointer, which moves only on block end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_own    <= '0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_state  <= IDLE;
                r_rr_ptr <= w_rr_next;
            end else begin
                r_state <= LOCKED;
                r_own   <= w_idx;
            end
        end
    end

    // Single output register; holds its beat until the vector stage takes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dst_rdy <= 1'b0;
            r_id      <= '0;
            r_linear1 <= '0;
            r_linear2 <= '0;
            r_bofs    <= '0;
            r_retire  <= 1'b0;
            r_islast  <= 1'b0;
        end else if (w_accept) begin
            r_dst_rdy <= 1'b1;
            r_id      <= i_id[w_idx];
            r_linear1 <= i_linear1[w_idx];
            r_linear2 <= i_linear2[w_idx];
            r_bofs    <= i_bofs[w_idx];
            r_retire  <= i_retire[w_idx];
            r_islast  <= w_last;
        end else if (dst_ack) begin
            r_dst_rdy <= 1'b0;
        end
    end

    // Sticky flag for a fin with no block outstanding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)               r_err <= 1'b0;
        else if (fin_dval && w_empty) r_err <= 1'b1;
    end

    assign dst_rdy   = r_dst_rdy;
    assign o_id      = r_id;
    assign o_linear1 = r_linear1;
    assign o_linear2 = r_linear2;
    assign o_bofs    = r_bofs;
    assign o_retire  = r_retire;
    assign o_islast  = r_islast;
    assign o_err     = r_err;

endmodule

// File: tb/tb_accum_vector_arbiter.sv
// Directed + randomized bench for accum_vector_arbiter against a queue-based model.
module tb_accum_vector_arbiter;
    localparam int N = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]      id;
        logic [15:0]     l1;
        logic [15:0]     l2;
        logic [1:0][7:0] bofs;
        logic            ret;
        logic            last;
    } beat_t;

    logic                    i_clk = 1'b0;
    logic                    i_rst_n;
    logic [N-1:0]            req_rdy;
    logic [N-1:0]            req_ack;
    logic [N-1:0][2:0]       i_id;
    logic [N-1:0][15:0]      i_linear1, i_linear2;
    logic [N-1:0][1:0][7:0]  i_bofs;
    logic [N-1:0]            i_retire, i_islast;
    logic                    dst_rdy, dst_ack;
    logic [2:0]              o_id;
    logic [15:0]             o_linear1, o_linear2;
    logic [1:0][7:0]         o_bofs;
    logic                    o_retire, o_islast;
    logic                    fin_dval;
    logic [N-1:0]            o_fin_dval;
    logic                    o_err;

    accum_vector_arbiter #(.N_REQ(N), .N_CFG(4), .ABW(16), .FIN_DEPTH(DEPTH), .WBW(8), .DIM(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .req_rdy(req_rdy), .req_ack(req_ack),
        .i_id(i_id), .i_linear1(i_linear1), .i_linear2(i_linear2), .i_bofs(i_bofs),
        .i_retire(i_retire), .i_islast(i_islast), .dst_rdy(dst_rdy), .dst_ack(dst_ack),
        .o_id(o_id), .o_linear1(o_linear1), .o_linear2(o_linear2), .o_bofs(o_bofs),
        .o_retire(o_retire), .o_islast(o_islast), .fin_dval(fin_dval),
        .o_fin_dval(o_fin_dval), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    wire [52:0] obeat = {o_id, o_linear1, o_linear2, o_bofs, o_retire, o_islast};

    // Requester sources: queue of block lengths, beat index, current beat data.
    int    blkq[N][$];
    int    bidx[N];
    bit    en[N];
    beat_t cur[N];

    // Reference model: owner (-1 = none), rr pointer, in-flight owners, held beat.
    int    m_own, m_rr;
    int    m_fifo[$];
    bit    m_err, m_vld;
    beat_t m_out;

    int         errs = 0, checks = 0;
    int         acc_log[$];
    logic [1:0] last_ack, last_fin;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic newbeat(input int r);
        cur[r].id   = 3'($urandom_range(0, 4));
        cur[r].l1   = 16'($urandom);
        cur[r].l2   = 16'($urandom);
        cur[r].bofs = 16'($urandom);
        cur[r].ret  = 1'($urandom);
        cur[r].last = 1'b0;
    endtask

    task automatic model_reset();
        m_own = -1; m_rr = 0; m_fifo.delete(); m_err = 0; m_vld = 0; m_out = '0;
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            req_rdy[r]   = (blkq[r].size() > 0) && en[r];
            i_id[r]      = cur[r].id;
            i_linear1[r] = cur[r].l1;
            i_linear2[r] = cur[r].l2;
            i_bofs[r]    = cur[r].bofs;
            i_retire[r]  = cur[r].ret;
            i_islast[r]  = (blkq[r].size() > 0) && (bidx[r] == blkq[r][0] - 1);
        end
    endtask

    function automatic beat_t beat_in(input int r);
        beat_t b;
        b.id = i_id[r]; b.l1 = i_linear1[r]; b.l2 = i_linear2[r];
        b.bofs = i_bofs[r]; b.ret = i_retire[r]; b.last = i_islast[r];
        return b;
    endfunction

    // One clock: drive after negedge, check combinational outputs, step model, check registers.
    task automatic cycle();
        logic [1:0] eack, efin;
        int  cand;
        bit  free, acc, lst;
        drive();
        #1;
        free = !m_vld || dst_ack;
        cand = -1;
        if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (req_rdy[j] && cand < 0) cand = j;
            end
        end else if (req_rdy[m_own]) cand = m_own;
        lst  = (cand >= 0) ? i_islast[cand] : 1'b0;
        acc  = (cand >= 0) && free && !(lst && m_fifo.size() == DEPTH);
        eack = '0;
        if (acc) eack[cand] = 1'b1;
        efin = '0;
        if (fin_dval && m_fifo.size() > 0) efin[m_fifo[0]] = 1'b1;
        last_ack = req_ack;
        last_fin = o_fin_dval;
        chk("req_ack", req_ack, eack);
        chk("fin_route", o_fin_dval, efin);
        if (fin_dval) begin
            if (m_fifo.size() > 0) void'(m_fifo.pop_front());
            else m_err = 1;
        end
        if (acc) begin
            acc_log.push_back(cand);
            m_out = beat_in(cand);
            m_vld = 1;
            if (lst) begin
                m_fifo.push_back(cand);
                m_own = -1;
                m_rr  = (cand + 1) % N;
            end else m_own = cand;
        end else if (dst_ack) m_vld = 0;
        @(posedge i_clk);
        #1;
        if (acc) begin
            if (lst) begin
                void'(blkq[cand].pop_front());
                bidx[cand] = 0;
            end else bidx[cand]++;
            newbeat(cand);
        end
        chk("dst_rdy", dst_rdy, m_vld);
        if (m_vld) chk("beat", obeat, m_out);
        chk("err", o_err, m_err);
        @(negedge i_clk);
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while ((blkq[0].size() > 0 || blkq[1].size() > 0) && c < maxc) begin
            cycle();
            c++;
        end
        chk("drain_timeout", (c < maxc), 1);
    endtask

    task automatic flush();
        en[0] = 0; en[1] = 0; fin_dval = 1;
        while (m_fifo.size() > 0) cycle();
        fin_dval = 0; en[0] = 1; en[1] = 1;
    endtask

    initial begin
        int exp_ord[6];
        int first_owner;
        exp_ord = '{0, 0, 0, 1, 1, 1};
        for (int r = 0; r < N; r++) begin bidx[r] = 0; en[r] = 1; newbeat(r); end
        dst_ack = 1; fin_dval = 0;
        i_rst_n = 0;
        model_reset();
        drive();
        #1;
        chk("reset_outputs", {dst_rdy, obeat, o_fin_dval, o_err, req_ack}, 0);
        @(posedge i_clk); @(negedge i_clk);
        i_rst_n = 1;

        // Arbitration order with two 3-beat blocks.
        blkq[0].push_back(3); blkq[1].push_back(3);
        acc_log.delete();
        drain(20);
        chk("arb_count", acc_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("arb_order", (i < acc_log.size()) ? acc_log[i] : -1, exp_ord[i]);
        flush();
        blkq[0].push_back(1); blkq[1].push_back(1);
        acc_log.delete();
        drain(10);
        chk("rr_back_to_0", (acc_log.size() > 0) ? acc_log[0] : -1, 0);
        flush();

        // Lock hold: req0 stalls mid-block, req1 must wait.
        blkq[0].push_back(3); blkq[1].push_back(1);
        cycle();
        en[0] = 0;
        repeat (5) begin
            cycle();
            chk("lock_hold", last_ack[1], 0);
        end
        en[0] = 1;
        drain(20);
        flush();

        // Backpressure: output held, no acks, release accepts in same cycle.
        blkq[0].push_back(3);
        cycle();
        dst_ack = 0;
        repeat (4) begin
            cycle();
            chk("bp_no_ack", last_ack, 0);
        end
        dst_ack = 1;
        cycle();
        chk("bp_release", last_ack, 2'b01);
        drain(20);
        flush();

        // Owner FIFO full: fifth single-beat block stalls until a fin.
        repeat (3) blkq[0].push_back(1);
        repeat (2) blkq[1].push_back(1);
        acc_log.delete();
        repeat (6) cycle();
        chk("fifo_full_stall", last_ack, 0);
        chk("fifo_accepts", acc_log.size(), 4);
        first_owner = (acc_log.size() > 0) ? acc_log[0] : 0;
        fin_dval = 1;
        cycle();
        chk("fifo_first_owner", last_fin, 2'b01 << first_owner);
        chk("fifo_still_stalled", last_ack, 0);
        fin_dval = 0;
        cycle();
        chk("fifo_unstall", |last_ack, 1);
        flush();

        // Fin routing in owner order 1,0,1.
        blkq[1].push_back(1); drain(10);
        blkq[0].push_back(1); drain(10);
        blkq[1].push_back(1); drain(10);
        en[0] = 0; en[1] = 0; fin_dval = 1;
        cycle(); chk("fin_seq0", last_fin, 2'b10);
        cycle(); chk("fin_seq1", last_fin, 2'b01);
        cycle(); chk("fin_seq2", last_fin, 2'b10);
        fin_dval = 0; en[0] = 1; en[1] = 1;

        // Fin with empty FIFO: sticky error.
        fin_dval = 1;
        cycle();
        chk("err_no_fin", last_fin, 0);
        fin_dval = 0;
        repeat (3) begin
            cycle();
            chk("err_sticky", o_err, 1);
        end

        // Randomized traffic.
        repeat (80) begin
            for (int r = 0; r < N; r++) begin
                if (blkq[r].size() == 0) blkq[r].push_back($urandom_range(1, 4));
                en[r] = ($urandom_range(0, 3) != 0);
            end
            dst_ack  = ($urandom_range(0, 3) != 0);
            fin_dval = ($urandom_range(0, 2) == 0);
            cycle();
        end
        en[0] = 1; en[1] = 1; dst_ack = 1; fin_dval = 1;
        drain(100);
        fin_dval = 0;
        flush();

        // Async reset mid-block.
        blkq[0].push_back(4);
        cycle(); cycle();
        chk("pre_reset_busy", dst_rdy, 1);
        blkq[0].delete(); blkq[1].delete(); bidx[0] = 0; bidx[1] = 0;
        drive();
        #2;
        i_rst_n = 0;
        #1;
        chk("async_reset", {dst_rdy, obeat, o_fin_dval, o_err, req_ack}, 0);
        model_reset();
        @(posedge i_clk); @(negedge i_clk);
        i_rst_n = 1;
        blkq[1].push_back(1);
        cycle();
        chk("post_reset_req1", last_ack, 2'b10);
        blkq[0].push_back(1); blkq[1].push_back(1);
        cycle();
        chk("post_reset_req0_first", last_ack, 2'b01);
        drain(10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
